// File: rtl/key_debounce_edge.sv
// Pushbutton conditioner: 2-flop sync, per-key stability counter, edge pulses and sticky press flags.
// Latency: level and pulse change DEBOUNCE_CYCLES+1 edges after the pad change is first sampled.
// Backpressure: none; the block runs every cycle and its outputs are not held.
module key_debounce_edge #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_KEYS-1:0] clear_mask,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic [NUM_KEYS-1:0] keys_pressed,
    output logic [NUM_KEYS-1:0] keys_released,
    output logic [NUM_KEYS-1:0] press_sticky
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] s;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    // Reset to all-ones so a key held through reset looks released and must re-qualify.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n_in;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            keys_level    <= '0;
            keys_pressed  <= '0;
            keys_released <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            keys_pressed  <= '0;
            keys_released <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (s[i] == keys_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    keys_level[i]    <= s[i];
                    keys_pressed[i]  <= s[i];
                    keys_released[i] <= ~s[i];
                    cnt[i]           <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // The press pulse is ORed in after the clear so a coincident clear cannot drop a press.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            press_sticky <= '0;
        end else begin
            press_sticky <= (press_sticky & ~clear_mask) | keys_pressed;
        end
    end

endmodule

// File: doc/key_debounce_edge.md
Name: key_debounce_edge

Overview:
- Upstream conditioning stage for the four active-low pushbuttons ahead of the Nios keys PIO.
- Per key, the block:
  - synchronises the raw pad to CLOCK_50;
  - rejects bounce shorter than DEBOUNCE_CYCLES;
  - produces an active-high debounced level, one-cycle press/release pulses, and sticky press flags that software clears.
- keys_level replaces the direct inversion of KEY at the PIO input.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new level must hold before acceptance (10 ms at 50 MHz). Legal range 2..2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-key stability counter (derived; not overridden).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- reset_n  in  1  asynchronous active-low reset, deasserted synchronously upstream.
- key_n_in  in  NUM_KEYS  raw pushbutton pads, active-low (0 = pressed), asynchronous.
- clear_mask  in  NUM_KEYS  one-cycle strobe; bit i clears press_sticky[i].
- keys_level  out  NUM_KEYS  debounced level, active-high (1 = pressed).
- keys_pressed  out  NUM_KEYS  one-cycle pulse on accepted 0->1 of keys_level.
- keys_released  out  NUM_KEYS  one-cycle pulse on accepted 1->0 of keys_level.
- press_sticky  out  NUM_KEYS  set by keys_pressed, held until cleared.

Behaviour:
- Reset values (reset_n low, immediate):
  - synchroniser flops = 1 (released);
  - counters = 0;
  - keys_level, keys_pressed, keys_released, press_sticky = 0.
- Synchroniser: two flops per key; s = ~sync2 (active-high sampled level). No logic between sync1 and sync2.
- Per-key state is lvl (= keys_level[i]) plus cnt[CNT_W-1:0]. Each cycle:
  - s == lvl: cnt <= 0, no pulse.
  - s != lvl and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s, cnt <= 0, matching pulse asserted for the next cycle only. The pulse is keys_pressed if s=1, keys_released if s=0.
- Any single cycle of s == lvl during counting restarts the count from 0. Bounce shorter than DEBOUNCE_CYCLES never changes keys_level.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Latency: raw change first sampled at edge E0 -> keys_level and pulse change at edge E0+DEBOUNCE_CYCLES+1. Pulse width is exactly 1 cycle. keys_pressed and keys_released are never both high on the same bit.
- Pulses are registered outputs, coincident with the keys_level transition (same edge).
- press_sticky[i]:
  - set when keys_pressed[i] is asserted;
  - cleared when clear_mask[i]=1;
  - if set and clear occur in the same cycle, set wins (press not lost).
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses.
- Reset mid-count discards the partial count; after release, the key is treated as released and must re-qualify for the full DEBOUNCE_CYCLES.
- Key held across reset: keys_level stays 0 until the full qualification after reset, then a keys_pressed pulse is issued.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=8 for simulation):
1. Assert reset_n=0 with key_n_in=4'b0000 -> all outputs 0 during reset. Release reset, hold -> keys_level=4'b1111 and keys_pressed=4'b1111 for one cycle at edge 9 after the first sample, press_sticky=4'b1111.
2. From idle, drive key_n_in[0]=0 for 5 cycles then 1, repeated 3 times -> keys_level[0] stays 0, no pulses. Then hold 0 for 20 cycles -> keys_level[0]=1 exactly 9 edges after the first sampled low, keys_pressed[0] high 1 cycle.
3. Key 0 pressed and stable, drive key_n_in[0]=1 steady -> keys_released[0] pulses once after 9 edges, keys_level[0]=0, press_sticky[0] remains 1.
4. Assert clear_mask=4'b0001 in the same cycle keys_pressed[0] pulses -> press_sticky[0] stays 1. Assert clear_mask=4'b0001 on a later cycle -> press_sticky[0]=0, other bits unchanged.
5. Drive key_n_in[2] low for 6 cycles, pulse reset_n low 1 cycle, keep key low -> no pulse at the original deadline. keys_pressed[2] appears 9 edges after reset release sampling resumes.
6. Press keys 1 and 3 on the same cycle with independent bounce patterns (key 1 clean, key 3 bouncing 3 cycles then clean) -> key 1 pulses at +9, key 3 pulses 9 edges after its last bounce; key 0 and key 2 outputs remain 0 throughout.
